// File: rtl/scan_mux_bank_seq.sv
// Multi-channel scan/functional mux with a synchronised scan request and a
// sequenced mode change that holds outputs at a safe value on entry and exit.
module scan_mux_bank_seq #(
    parameter int                         NUM_CH      = 4,
    parameter int                         WIDTH       = 1,
    parameter int                         SYNC_STAGES = 2,
    parameter int                         GATE_CYCLES = 4,
    parameter logic [NUM_CH*WIDTH-1:0]    SAFE_VAL    = '0,
    parameter logic [NUM_CH-1:0]          BYPASS_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      scan_mode_req_in,
    input  logic [NUM_CH*WIDTH-1:0]   scan_signal_in,
    input  logic [NUM_CH*WIDTH-1:0]   fcn_signal_in,
    output logic [NUM_CH*WIDTH-1:0]   fcn_signal_out,
    output logic                      scan_active_out,
    output logic                      switching_out
);

    localparam int                CNT_W    = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_FCN      = 2'd0,
        ST_GATE_IN  = 2'd1,
        ST_SCAN     = 2'd2,
        ST_GATE_OUT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_scan_active;
    logic                   r_switching;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], scan_mode_req_in};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // Status flops are loaded together with the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FCN;
            r_cnt         <= '0;
            r_scan_active <= 1'b0;
            r_switching   <= 1'b0;
        end else begin
            case (r_state)
                ST_FCN: begin
                    if (w_req_s) begin
                        r_state     <= ST_GATE_IN;
                        r_cnt       <= CNT_LOAD;
                        r_switching <= 1'b1;
                    end
                end
                ST_GATE_IN: begin
                    if (r_cnt == '0) begin
                        r_state       <= ST_SCAN;
                        r_switching   <= 1'b0;
                        r_scan_active <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!w_req_s) begin
                        r_state       <= ST_GATE_OUT;
                        r_cnt         <= CNT_LOAD;
                        r_scan_active <= 1'b0;
                        r_switching   <= 1'b1;
                    end
                end
                ST_GATE_OUT: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_FCN;
                        r_switching <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_FCN;
                    r_cnt         <= '0;
                    r_scan_active <= 1'b0;
                    r_switching   <= 1'b0;
                end
            endcase
        end
    end

    assign scan_active_out = r_scan_active;
    assign switching_out   = r_switching;

    // Data path stays combinational; only the select comes from flops.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        if (BYPASS_MASK[gi]) begin : g_bypass
            assign fcn_signal_out[gi*WIDTH +: WIDTH] = fcn_signal_in[gi*WIDTH +: WIDTH];
        end else begin : g_mux
            logic [WIDTH-1:0] w_ch_mux;
            always_comb begin
                w_ch_mux = fcn_signal_in[gi*WIDTH +: WIDTH];
                case (r_state)
                    ST_SCAN:                 w_ch_mux = scan_signal_in[gi*WIDTH +: WIDTH];
                    ST_GATE_IN, ST_GATE_OUT: w_ch_mux = SAFE_VAL[gi*WIDTH +: WIDTH];
                    default:                 w_ch_mux = fcn_signal_in[gi*WIDTH +: WIDTH];
                endcase
            end
            assign fcn_signal_out[gi*WIDTH +: WIDTH] = w_ch_mux;
        end
    end

endmodule

// File: tb/tb_scan_mux_bank_seq.sv
// Bench for scan_mux_bank_seq: a default instance plus a bypass/safe-value
// instance, checked against vector tables and a phase-level reference model.
module tb_scan_mux_bank_seq;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 1;
    localparam int NW     = NUM_CH * WIDTH;
    localparam int SYNC   = 2;
    localparam int GATE   = 4;
    localparam logic [NUM_CH-1:0] MASK_A = 4'b0000;
    localparam logic [NW-1:0]     SAFE_A = 4'b0000;
    localparam logic [NUM_CH-1:0] MASK_B = 4'b0010;
    localparam logic [NW-1:0]     SAFE_B = 4'b1000;

    localparam int P_FCN  = 0;
    localparam int P_IN   = 1;
    localparam int P_SCAN = 2;
    localparam int P_OUT  = 3;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst_n = 1'b1;
    logic          req = 1'b0;
    logic [NW-1:0] fcn = '0;
    logic [NW-1:0] scan = '0;
    logic [NW-1:0] out_a, out_b;
    logic          sa_a, sw_a, sa_b, sw_b;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: requests seen by the FSM lag by SYNC edges; each gated
    // phase lasts GATE cycles counted down from entry.
    int m_phase;
    int m_left;
    bit m_hist[$];

    typedef struct {
        bit          req;
        logic [3:0]  fcn;
        logic [3:0]  scan;
        logic [3:0]  exp_a;
        logic [3:0]  exp_b;
        bit          exp_sa;
        bit          exp_sw;
    } vec_t;

    vec_t vecs[15];

    scan_mux_bank_seq #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .GATE_CYCLES(GATE),
        .SAFE_VAL(SAFE_A), .BYPASS_MASK(MASK_A)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .scan_mode_req_in(req),
        .scan_signal_in(scan), .fcn_signal_in(fcn), .fcn_signal_out(out_a),
        .scan_active_out(sa_a), .switching_out(sw_a)
    );

    scan_mux_bank_seq #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .GATE_CYCLES(GATE),
        .SAFE_VAL(SAFE_B), .BYPASS_MASK(MASK_B)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .scan_mode_req_in(req),
        .scan_signal_in(scan), .fcn_signal_in(fcn), .fcn_signal_out(out_b),
        .scan_active_out(sa_b), .switching_out(sw_b)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_FCN;
        m_left  = 0;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_edge(input bit r);
        bit rs;
        rs = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(r);
        case (m_phase)
            P_FCN:  if (rs) begin m_phase = P_IN; m_left = GATE; end
            P_SCAN: if (!rs) begin m_phase = P_OUT; m_left = GATE; end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = (m_phase == P_IN) ? P_SCAN : P_FCN;
            end
        endcase
    endtask

    function automatic logic [NW-1:0] model_out(input logic [NUM_CH-1:0] mask,
                                                input logic [NW-1:0] safe);
        logic [NW-1:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) begin
            if (mask[i / WIDTH] || m_phase == P_FCN) r[i] = fcn[i];
            else if (m_phase == P_SCAN)              r[i] = scan[i];
            else                                     r[i] = safe[i];
        end
        return r;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_out_a"}, 32'(out_a), 32'(model_out(MASK_A, SAFE_A)));
        chk({tag, "_out_b"}, 32'(out_b), 32'(model_out(MASK_B, SAFE_B)));
        chk({tag, "_scan_active"}, 32'(sa_a), 32'(m_phase == P_SCAN));
        chk({tag, "_switching"}, 32'(sw_b), 32'(m_phase == P_IN || m_phase == P_OUT));
    endtask

    task automatic step(input string tag);
        bit r;
        @(posedge clk);
        r = req;
        model_edge(r);
        #1;
        check_model(tag);
        $display("%s t=%0t req=%0b fcn=%h scan=%h out_a=%h out_b=%h sa=%0b sw=%0b",
                 tag, $time, r, fcn, scan, out_a, out_b, sa_a, sw_a);
    endtask

    initial begin
        int scan_cycles;
        bit early_fcn;
        bit reached;

        // entry at edge 0, exit request sampled at edge 8
        for (int i = 0; i < 15; i++) begin
            vecs[i].fcn  = 4'hA;
            vecs[i].scan = 4'h5;
            vecs[i].req  = (i < 8);
            if (i < 2 || i == 14) begin
                vecs[i].exp_a = 4'hA; vecs[i].exp_b = 4'hA; vecs[i].exp_sa = 0; vecs[i].exp_sw = 0;
            end else if (i < 6 || (i >= 10 && i < 14)) begin
                vecs[i].exp_a = 4'h0; vecs[i].exp_b = 4'b1010; vecs[i].exp_sa = 0; vecs[i].exp_sw = 1;
            end else begin
                vecs[i].exp_a = 4'h5; vecs[i].exp_b = 4'b0111; vecs[i].exp_sa = 1; vecs[i].exp_sw = 0;
            end
        end

        // Reset with no clock running.
        fcn = 4'hA; scan = 4'h5; req = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_noclk_out_a", 32'(out_a), 32'h0000000A);
        chk("rst_noclk_out_b", 32'(out_b), 32'h0000000A);
        chk("rst_noclk_sa", 32'(sa_a), 32'd0);
        chk("rst_noclk_sw", 32'(sw_a), 32'd0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out_a", 32'(out_a), 32'h0000000A);
        chk("rst_clk_sw_b", 32'(sw_b), 32'd0);
        rst_n = 1'b1;
        model_reset();
        step("idle");
        step("idle");

        for (int i = 0; i < 15; i++) begin
            req = vecs[i].req; fcn = vecs[i].fcn; scan = vecs[i].scan;
            @(posedge clk);
            model_edge(req);
            #1;
            chk($sformatf("vec%0d_out_a", i), 32'(out_a), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_out_b", i), 32'(out_b), 32'(vecs[i].exp_b));
            chk($sformatf("vec%0d_sa", i), 32'(sa_a), 32'(vecs[i].exp_sa));
            chk($sformatf("vec%0d_sw", i), 32'(sw_a), 32'(vecs[i].exp_sw));
            $display("vec%0d t=%0t req=%0b out_a=%h out_b=%h sa=%0b sw=%0b",
                     i, $time, req, out_a, out_b, sa_a, sw_a);
        end

        // Request dropped one cycle into GATE_IN: entry must still complete.
        req = 1'b1;
        for (int i = 0; i < 10 && m_phase != P_IN; i++) step("drop_wait");
        chk("drop_in_gate_in", 32'(sw_a), 32'd1);
        step("drop_hold");
        req = 1'b0;
        scan_cycles = 0; early_fcn = 1'b0;
        for (int i = 0; i < 30 && !(m_phase == P_FCN && scan_cycles > 0); i++) begin
            step("drop_run");
            if (sa_a) scan_cycles++;
            if (!sa_a && !sw_a && scan_cycles == 0) early_fcn = 1'b1;
        end
        chk("drop_scan_held", 32'(scan_cycles >= 1), 32'd1);
        chk("drop_no_direct_exit", 32'(early_fcn), 32'd0);
        chk("drop_back_fcn", 32'(out_a), 32'(fcn));

        // Pulse between edges is never captured.
        @(negedge clk); req = 1'b1; #2 req = 1'b0;
        for (int i = 0; i < 6; i++) step("pulse_miss");

        // One-cycle pulse that is captured runs the full round trip.
        req = 1'b1;
        step("pulse_hit");
        req = 1'b0;
        scan_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step("pulse_run");
            if (sa_a) scan_cycles++;
        end
        chk("pulse_scan_cycles", 32'(scan_cycles >= 1), 32'd1);
        chk("pulse_return_fcn", 32'(sw_a | sa_a), 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            fcn  = NW'($urandom);
            scan = NW'($urandom);
            step("rand");
        end

        // Asynchronous reset in SCAN with the clock stopped.
        req = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step("to_scan");
            if (m_phase == P_SCAN) reached = 1'b1;
        end
        chk("reset_pre_scan", 32'(sa_a), 32'd1);
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_a", 32'(out_a), 32'(fcn));
        chk("midrst_out_b", 32'(out_b), 32'(fcn));
        chk("midrst_sa", 32'(sa_a), 32'd0);
        chk("midrst_sw", 32'(sw_b), 32'd0);
        fcn = 4'h3;
        #1;
        chk("midrst_follow", 32'(out_a), 32'h00000003);
        model_reset();
        #2 rst_n = 1'b1;
        clk_en = 1'b1;
        step("post_rst1");
        chk("post_rst1_sw", 32'(sw_a), 32'd0);
        step("post_rst2");
        chk("post_rst2_sw", 32'(sw_a), 32'd0);
        step("post_rst3");
        chk("post_rst3_sw", 32'(sw_a), 32'd1);
        for (int i = 0; i < 6; i++) step("post_rst_run");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_mux_bank_seq.md
Name: scan_mux_bank_seq

Overview:
- Parametrised, multi-channel successor to the single-bit scan mux cell.
- Switches NUM_CH functional buses between functional and scan sources under a sequenced, glitch-safe mode change:
  - synchronised scan request;
  - forced safe-value gating window on entry and on exit.
- Sits at the scan/DFT boundary of the tc_synth clusters, in front of scan clock/reset/control distribution.
- Mode selection is registered; data paths stay combinational through the mux.

Parameters:
- NUM_CH, 4, number of independent channels.
- WIDTH, 1, bits per channel.
- SYNC_STAGES, 2, synchroniser depth for scan_mode_req_in. Legal range ≥2.
- GATE_CYCLES, 4, cycles outputs are held at safe value during each transition. Legal range ≥1.
- SAFE_VAL, {NUM_CH*WIDTH{1'b0}}, per-bit value driven during gating.
- BYPASS_MASK, {NUM_CH{1'b0}}, bit c=1 means channel c never switches and always passes fcn_signal_in.

Ports:
- clk  in  1  free-running control clock.
- rst_n  in  1  asynchronous assert, active-low reset.
- scan_mode_req_in  in  1  scan mode request; may be asynchronous to clk.
- scan_signal_in  in  NUM_CH*WIDTH  scan-side sources; channel c is bits [c*WIDTH +: WIDTH].
- fcn_signal_in  in  NUM_CH*WIDTH  functional sources.
- fcn_signal_out  out  NUM_CH*WIDTH  muxed outputs.
- scan_active_out  out  1  high only in state SCAN.
- switching_out  out  1  high in GATE_IN and GATE_OUT.

Behaviour:
- Synchroniser:
  - SYNC_STAGES flops, all reset to 0.
  - req_s is the last stage.
- FSM, states FCN, GATE_IN, SCAN, GATE_OUT, 2-bit encoded. Reset state FCN. Gate counter cnt is $clog2(GATE_CYCLES+1) bits, reset 0.
- FCN:
  - Outputs = fcn_signal_in.
  - If req_s=1: go to GATE_IN, load cnt=GATE_CYCLES-1.
- GATE_IN:
  - Non-bypass channels output SAFE_VAL bits.
  - If cnt!=0: cnt decrements.
  - If cnt==0: go to SCAN.
  - req_s is ignored in this state; a sequence that has started always completes.
- SCAN:
  - Non-bypass channels output scan_signal_in.
  - If req_s=0: go to GATE_OUT, load cnt=GATE_CYCLES-1.
- GATE_OUT:
  - Outputs SAFE_VAL, same counting as GATE_IN.
  - If cnt==0: go to FCN.
  - req_s is ignored in this state.
- Bypass channels output fcn_signal_in in every state.
- Output mux:
  - Combinational from the registered state to the data inputs; zero data latency.
  - No output flop is added.
  - Select lines come only from state flops, so there are no select glitches.
- Timing:
  - scan_mode_req_in is first sampled 1 at edge k, so req_s=1 after edge k+SYNC_STAGES-1.
  - State = GATE_IN after edge k+SYNC_STAGES.
  - State = SCAN after edge k+SYNC_STAGES+GATE_CYCLES.
  - Exit is symmetric.
- Request pulse shorter than the synchroniser window:
  - No action if it is never captured.
  - If captured, the full entry completes. SCAN is then held ≥1 cycle, then exit proceeds.
- Reset, asynchronous, including mid-sequence:
  - State=FCN, cnt=0, synchroniser cleared.
  - scan_active_out=0, switching_out=0.
  - fcn_signal_out=fcn_signal_in immediately, with no clock required.
- Status outputs are decoded from the registered state and are glitch-free.

Test Plan:
- Reset and functional pass-through:
  - Stimulus: rst_n=0, fcn_signal_in=4'hA, scan_signal_in=4'h5 (NUM_CH=4, WIDTH=1).
  - Required: fcn_signal_out=4'hA; both status outputs 0. Same after rst_n release while req=0.
- Scan entry:
  - Stimulus: raise req at edge 0.
  - Required: switching_out=1 after edge 2; fcn_signal_out=4'h0 for 4 cycles; scan_active_out=1 and fcn_signal_out=4'h5 after edge 6.
- Scan exit:
  - Stimulus: drop req while in SCAN.
  - Required: GATE_OUT after 2 edges; outputs 4'h0 for 4 cycles; then FCN with fcn_signal_out=4'hA.
- Request drop during GATE_IN:
  - Stimulus: deassert req 1 cycle after entering GATE_IN.
  - Required: SCAN is still reached, lasts ≥1 cycle, then GATE_OUT, then FCN. No direct GATE_IN→FCN transition.
- Bypass and safe value:
  - Configuration: BYPASS_MASK=4'b0010, SAFE_VAL=4'b1000.
  - Required in gating: output 4'b1010 given fcn=4'hA.
  - Required in SCAN: output bit1=fcn bit1, other bits=scan.
- Reset mid-sequence:
  - Stimulus: assert rst_n=0 during SCAN while clk is stopped.
  - Required: output returns to fcn_signal_in immediately; scan_active_out=0.
  - After release with req=1: full entry sequence replays, GATE_IN reached 3 edges after release.
